cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Common-data-bus transmitter for the Tomasulo core. Collects completed results (ROB tag + 32-bit value) from the functional units / reservation stations, buffers them per source, and drives the two CDB channels (`CDBiscast/CDBrobNum/CDBdata` and `CDBiscast2/CDBrobNum2/CDBdata2`) that every reservation station, the ROB and the register status table snoop. At most two results retire onto the bus per cycle, and sources are served in round-robin order.

## Interface
- `NUM_SRC`, 4: number of result producers (add RS, mem, branch, mul).
- `FIFO_DEPTH`, 2: entries per source buffer; power of two, ≥2.
- `ROB_W`, 6: ROB tag width.
- `DATA_W`, 32: result width.
- `INVALID_TAG`, 6'b010000: tag driven when a channel is idle.

- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low.
- `flush`  in  1  synchronous mispredict flush; discards all buffered and outgoing results.
- `src_valid`  in  NUM_SRC  source i presents a result this cycle.
- `src_robNum`  in  NUM_SRC*ROB_W  tags, source i at `[i*ROB_W +: ROB_W]`.
- `src_data`  in  NUM_SRC*DATA_W  values, same packing.
- `src_ready`  out  NUM_SRC  source i buffer not full; push accepted only when high.
- `CDBiscast`, `CDBrobNum`, `CDBdata`  out  1/ROB_W/DATA_W  channel 1.
- `CDBiscast2`, `CDBrobNum2`, `CDBdata2`  out  1/ROB_W/DATA_W  channel 2.
- `overflow`  out  1  sticky: a push arrived while `src_ready` was low.

## Operation
- Per source: circular FIFO with read pointer, write pointer and count (width log2(FIFO_DEPTH)+1). Push when `src_valid[i] && src_ready[i]`. `src_ready[i] = (count_i != FIFO_DEPTH)`, a combinational decode of registered count, independent of same-cycle pops.
- Arbitration, every cycle on the FIFO heads: scan sources starting at `rr_ptr`, wrapping modulo NUM_SRC. The first non-empty source is granted channel 1 and the second distinct non-empty source is granted channel 2. A source never gets both channels in one cycle, even with 2 entries.
- Granted heads are popped. Tag and data are registered onto their channel with `iscast`=1. A channel with no grant registers `iscast`=0, tag=INVALID_TAG, data=0.
- `rr_ptr` update: if any grant, next = (last granted index + 1) mod NUM_SRC. Otherwise unchanged.
- Push and pop on the same FIFO in the same cycle: both happen and count is unchanged. Pointers wrap at FIFO_DEPTH.
- `src_valid[i]` while not ready: data dropped, `overflow` set to 1 and held until reset.
- `flush`=1: at that edge all counts and pointers clear, both channels register idle values, `rr_ptr` clears to 0, and pushes in that cycle are discarded. `flush` has priority over push and pop. `overflow` is not cleared.
- Tags are forwarded unmodified. The block never checks for duplicates.

## Timing
- Reset values (async, immediate): `CDBiscast`/`CDBiscast2`=0, `CDBrobNum`/`CDBrobNum2`=INVALID_TAG, data=0, all FIFOs empty, `src_ready`=all 1, `rr_ptr`=0, `overflow`=0.
- Latency: a result pushed at edge N into an empty buffer with no competition appears on the CDB after edge N+1, valid for exactly one cycle. No combinational input-to-CDB path.
- `iscast` is a one-cycle pulse per result. Back-to-back results from different sources give consecutive pulses.
- Throughput: 2 results/cycle overall, 1/cycle per source. A source pushing every cycle with competition stalls via `src_ready`.
- Reset asserted mid-operation: all state is lost immediately, with no partial broadcast. After release, the first push is broadcast two edges later.

## Structure
- Shared core package (with the RS/ROB constants): `ROB_W`, `DATA_W`, `INVALID_TAG` (6'b010000), and a `cdb_msg` typedef {iscast, robNum, data}.
- One sub-module: `cdb_src_fifo` (parameterized DEPTH/width, push/pop/flush, count, full/empty), instantiated NUM_SRC times. Arbiter, round-robin pointer and output registers stay in `cdb_arbiter`.

## Test plan
- Reset then single push, src 2 tag 5 data 0x1234 → after 2 edges: `CDBiscast`=1, tag 5, data 0x1234 for one cycle; channel 2 stays idle with INVALID_TAG.
- All 4 sources push one result (tags 1–4) in the same cycle, `rr_ptr`=0 → cycle A: ch1=tag1, ch2=tag2; cycle B: ch1=tag3, ch2=tag4; afterwards `rr_ptr`=0.
- Source 0 only, pushing every cycle → one broadcast per cycle on ch1 and ch2 idle; `src_ready[0]` never drops.
- Sources 0 and 1 each hold two entries, with sustained pushes on 2 and 3 → grants rotate and no source waits more than 2 cycles; ordering within each source is preserved.
- Fill src 1 (2 entries, no pops, by keeping higher-priority sources busy), then push again → `src_ready[1]`=0, push dropped, `overflow`=1 and sticky.
- Buffers holding 3 entries, assert `flush` together with a new push → next cycle both channels idle, all `src_ready`=1, nothing broadcast afterwards.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared core constants for the CDB transmitter: tag/data widths, the idle
// tag every snooper ignores, and the message carried on one CDB channel.
package cdb_arbiter_pkg;

  localparam int ROB_W  = 6;
  localparam int DATA_W = 32;

  localparam logic [ROB_W-1:0] INVALID_TAG = 6'b010000;

  typedef struct packed {
    logic              iscast;
    logic [ROB_W-1:0]  robNum;
    logic [DATA_W-1:0] data;
  } cdb_msg;

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result buffer: circular FIFO with read/write pointers and an
// occupancy count. A push into a full buffer and a pop from an empty one are
// ignored; flush empties the buffer and beats any same-cycle push or pop.
module cdb_src_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 38
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign rdata     = mem_r[rd_ptr_r];

  // Pointer and occupancy tracking; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (flush) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clock) begin
    if (do_push_s && !flush) mem_r[wr_ptr_r] <= wdata;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus transmitter: buffers completed results per producer and
// retires up to two per cycle onto the two CDB channels, serving producers
// round-robin. Channel outputs are registered; there is no input-to-CDB path.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int                NUM_SRC     = 4,
  parameter int                FIFO_DEPTH  = 2,
  parameter int                ROB_W       = cdb_arbiter_pkg::ROB_W,
  parameter int                DATA_W      = cdb_arbiter_pkg::DATA_W,
  parameter logic [ROB_W-1:0]  INVALID_TAG = cdb_arbiter_pkg::INVALID_TAG
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*ROB_W-1:0]  src_robNum,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      CDBiscast,
  output logic [ROB_W-1:0]          CDBrobNum,
  output logic [DATA_W-1:0]         CDBdata,
  output logic                      CDBiscast2,
  output logic [ROB_W-1:0]          CDBrobNum2,
  output logic [DATA_W-1:0]         CDBdata2,
  output logic                      overflow
);

  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int ENT_W = ROB_W + DATA_W;

  logic [ENT_W-1:0]   head_s [NUM_SRC];
  logic [NUM_SRC-1:0] full_s;
  logic [NUM_SRC-1:0] empty_s;
  logic [NUM_SRC-1:0] pop_s;
  logic [SEL_W-1:0]   rr_ptr_r;
  logic [SEL_W-1:0]   rr_next_s;
  logic [SEL_W-1:0]   last_idx_s;
  logic [SEL_W-1:0]   scan_idx_s;
  logic [SEL_W:0]     scan_sum_s;
  logic [SEL_W-1:0]   g1_idx_s;
  logic [SEL_W-1:0]   g2_idx_s;
  logic               g1_vld_s;
  logic               g2_vld_s;

  // Ready is a decode of registered occupancy only, so a same-cycle pop never frees a slot early.
  assign src_ready = ~full_s;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (ENT_W)
    ) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (flush),
      .push  (src_valid[i]),
      .pop   (pop_s[i]),
      .wdata ({src_robNum[i*ROB_W +: ROB_W], src_data[i*DATA_W +: DATA_W]}),
      .rdata (head_s[i]),
      .full  (full_s[i]),
      .empty (empty_s[i])
    );
  end

  // Scan heads from rr_ptr with wrap: first non-empty source takes channel 1, next distinct one channel 2.
  always_comb begin
    g1_vld_s   = 1'b0;
    g2_vld_s   = 1'b0;
    g1_idx_s   = {SEL_W{1'b0}};
    g2_idx_s   = {SEL_W{1'b0}};
    scan_sum_s = {(SEL_W+1){1'b0}};
    scan_idx_s = {SEL_W{1'b0}};
    for (int k = 0; k < NUM_SRC; k++) begin
      scan_sum_s = {1'b0, rr_ptr_r} + (SEL_W+1)'(k);
      if (scan_sum_s >= (SEL_W+1)'(NUM_SRC)) begin
        scan_sum_s = scan_sum_s - (SEL_W+1)'(NUM_SRC);
      end else begin
        scan_sum_s = scan_sum_s;
      end
      scan_idx_s = scan_sum_s[SEL_W-1:0];
      if (!empty_s[scan_idx_s]) begin
        if (!g1_vld_s) begin
          g1_vld_s = 1'b1;
          g1_idx_s = scan_idx_s;
        end else if (!g2_vld_s) begin
          g2_vld_s = 1'b1;
          g2_idx_s = scan_idx_s;
        end else begin
          g2_vld_s = g2_vld_s;
        end
      end else begin
        g1_vld_s = g1_vld_s;
      end
    end
  end

  // Pop granted heads and compute the pointer just past the last granted source.
  always_comb begin
    pop_s = {NUM_SRC{1'b0}};
    if (g1_vld_s) begin
      pop_s[g1_idx_s] = 1'b1;
    end else begin
      pop_s = pop_s;
    end
    if (g2_vld_s) begin
      pop_s[g2_idx_s] = 1'b1;
      last_idx_s      = g2_idx_s;
    end else begin
      last_idx_s      = g1_idx_s;
    end
    if (last_idx_s == SEL_W'(NUM_SRC - 1)) begin
      rr_next_s = {SEL_W{1'b0}};
    end else begin
      rr_next_s = last_idx_s + SEL_W'(1);
    end
  end

  // Register both CDB channels and advance the round-robin pointer on any grant.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      CDBiscast  <= 1'b0;
      CDBrobNum  <= INVALID_TAG;
      CDBdata    <= {DATA_W{1'b0}};
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= INVALID_TAG;
      CDBdata2   <= {DATA_W{1'b0}};
      rr_ptr_r   <= {SEL_W{1'b0}};
    end else if (flush) begin
      CDBiscast  <= 1'b0;
      CDBrobNum  <= INVALID_TAG;
      CDBdata    <= {DATA_W{1'b0}};
      CDBiscast2 <= 1'b0;
      CDBrobNum2 <= INVALID_TAG;
      CDBdata2   <= {DATA_W{1'b0}};
      rr_ptr_r   <= {SEL_W{1'b0}};
    end else begin
      CDBiscast  <= g1_vld_s;
      CDBrobNum  <= g1_vld_s ? head_s[g1_idx_s][ENT_W-1 -: ROB_W] : INVALID_TAG;
      CDBdata    <= g1_vld_s ? head_s[g1_idx_s][DATA_W-1:0] : {DATA_W{1'b0}};
      CDBiscast2 <= g2_vld_s;
      CDBrobNum2 <= g2_vld_s ? head_s[g2_idx_s][ENT_W-1 -: ROB_W] : INVALID_TAG;
      CDBdata2   <= g2_vld_s ? head_s[g2_idx_s][DATA_W-1:0] : {DATA_W{1'b0}};
      if (g1_vld_s) rr_ptr_r <= rr_next_s;
    end
  end

  // Sticky record of any push offered to a full buffer; only reset clears it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if ((src_valid & ~src_ready) != {NUM_SRC{1'b0}}) begin
      overflow <= 1'b1;
    end else begin
      overflow <= overflow;
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: a table of directed vectors with
// hand-derived expectations, a mid-operation reset sequence, and randomized
// traffic checked against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int         NS    = 4;
  localparam int         DEPTH = 2;
  localparam logic [5:0] INV   = 6'b010000;

  logic          clock;
  logic          reset;
  logic          flush;
  logic [3:0]    src_valid;
  logic [23:0]   src_robNum;
  logic [127:0]  src_data;
  logic [3:0]    src_ready;
  logic          CDBiscast, CDBiscast2;
  logic [5:0]    CDBrobNum, CDBrobNum2;
  logic [31:0]   CDBdata, CDBdata2;
  logic          overflow;

  int checks;
  int errors;

  cdb_arbiter #(
    .NUM_SRC (NS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .src_valid  (src_valid),
    .src_robNum (src_robNum),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .CDBiscast  (CDBiscast),
    .CDBrobNum  (CDBrobNum),
    .CDBdata    (CDBdata),
    .CDBiscast2 (CDBiscast2),
    .CDBrobNum2 (CDBrobNum2),
    .CDBdata2   (CDBdata2),
    .overflow   (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: one queue of pending results per source, plain round-robin index.
  cdb_msg mq [NS][$];
  int     m_rr;
  logic   m_ovf;
  cdb_msg m_ch1, m_ch2;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NS; i++) mq[i].delete();
    m_rr  = 0;
    m_ovf = 1'b0;
    m_ch1 = '{iscast: 1'b0, robNum: INV, data: 32'h0};
    m_ch2 = '{iscast: 1'b0, robNum: INV, data: 32'h0};
  endtask

  // What the upcoming clock edge does, given the inputs currently driven.
  task automatic model_edge();
    logic [3:0] acc;
    int         ng;
    int         last;
    int         s;
    cdb_msg     e;
    for (int i = 0; i < NS; i++) acc[i] = src_valid[i] && (mq[i].size() < DEPTH);
    if ((src_valid & ~acc) != 4'b0) m_ovf = 1'b1;
    m_ch1 = '{iscast: 1'b0, robNum: INV, data: 32'h0};
    m_ch2 = '{iscast: 1'b0, robNum: INV, data: 32'h0};
    if (flush) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      m_rr = 0;
    end else begin
      ng = 0;
      last = 0;
      for (int k = 0; k < NS; k++) begin
        s = (m_rr + k) % NS;
        if (ng < 2 && mq[s].size() > 0) begin
          e = mq[s].pop_front();
          if (ng == 0) m_ch1 = e;
          else m_ch2 = e;
          last = s;
          ng++;
        end
      end
      if (ng > 0) m_rr = (last + 1) % NS;
      for (int i = 0; i < NS; i++) begin
        if (acc[i]) begin
          e.iscast = 1'b1;
          e.robNum = src_robNum[i*6 +: 6];
          e.data   = src_data[i*32 +: 32];
          mq[i].push_back(e);
        end
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic model_check(input string nm);
    logic [3:0] rdy;
    for (int i = 0; i < NS; i++) rdy[i] = (mq[i].size() != DEPTH);
    chk({nm, "_c1"},  64'(CDBiscast),  64'(m_ch1.iscast));
    chk({nm, "_t1"},  64'(CDBrobNum),  64'(m_ch1.robNum));
    chk({nm, "_d1"},  64'(CDBdata),    64'(m_ch1.data));
    chk({nm, "_c2"},  64'(CDBiscast2), 64'(m_ch2.iscast));
    chk({nm, "_t2"},  64'(CDBrobNum2), 64'(m_ch2.robNum));
    chk({nm, "_d2"},  64'(CDBdata2),   64'(m_ch2.data));
    chk({nm, "_rdy"}, 64'(src_ready),  64'(rdy));
    chk({nm, "_ovf"}, 64'(overflow),   64'(m_ovf));
  endtask

  typedef struct {
    logic [3:0]  v;
    logic        fl;
    logic [5:0]  tb;
    logic [31:0] db;
    logic        c1;
    logic [5:0]  t1;
    logic [31:0] d1;
    logic        c2;
    logic [5:0]  t2;
    logic [31:0] d2;
    logic [3:0]  rdy;
    logic        ovf;
  } vec_t;

  vec_t tv [24];

  function automatic vec_t mk(input logic [3:0] v, input logic fl, input logic [5:0] tb,
                              input logic [31:0] db, input logic c1, input logic [5:0] t1,
                              input logic [31:0] d1, input logic c2, input logic [5:0] t2,
                              input logic [31:0] d2, input logic [3:0] rdy, input logic ovf);
    vec_t r;
    r.v = v; r.fl = fl; r.tb = tb; r.db = db;
    r.c1 = c1; r.t1 = t1; r.d1 = d1;
    r.c2 = c2; r.t2 = t2; r.d2 = d2;
    r.rdy = rdy; r.ovf = ovf;
    return r;
  endfunction

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    flush      = 1'b0;
    src_valid  = 4'b0;
    src_robNum = 24'h0;
    src_data   = 128'h0;
    model_reset();

    // Source i pushes tag tb+i and data db+i; expectations are the outputs after that edge.
    //           v      fl    tb     db            c1    t1     d1            c2    t2     d2            rdy      ovf
    tv[0]  = mk(4'h4, 1'b0, 6'd3,  32'h0000_1232, 1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[1]  = mk(4'h0, 1'b0, 6'd0,  32'h0,         1'b1, 6'd5,  32'h0000_1234, 1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[2]  = mk(4'h0, 1'b1, 6'd0,  32'h0,         1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[3]  = mk(4'hF, 1'b0, 6'd1,  32'h0000_0100, 1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[4]  = mk(4'h0, 1'b0, 6'd0,  32'h0,         1'b1, 6'd1,  32'h0000_0100, 1'b1, 6'd2,  32'h0000_0101, 4'hF, 1'b0);
    tv[5]  = mk(4'h0, 1'b0, 6'd0,  32'h0,         1'b1, 6'd3,  32'h0000_0102, 1'b1, 6'd4,  32'h0000_0103, 4'hF, 1'b0);
    tv[6]  = mk(4'h0, 1'b0, 6'd0,  32'h0,         1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[7]  = mk(4'h1, 1'b0, 6'd20, 32'h0000_2000, 1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[8]  = mk(4'h1, 1'b0, 6'd21, 32'h0000_2100, 1'b1, 6'd20, 32'h0000_2000, 1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[9]  = mk(4'h1, 1'b0, 6'd22, 32'h0000_2200, 1'b1, 6'd21, 32'h0000_2100, 1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[10] = mk(4'h0, 1'b0, 6'd0,  32'h0,         1'b1, 6'd22, 32'h0000_2200, 1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[11] = mk(4'h0, 1'b0, 6'd0,  32'h0,         1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[12] = mk(4'h0, 1'b1, 6'd0,  32'h0,         1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[13] = mk(4'h2, 1'b0, 6'd30, 32'h0000_3000, 1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[14] = mk(4'h0, 1'b0, 6'd0,  32'h0,         1'b1, 6'd31, 32'h0000_3001, 1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[15] = mk(4'hE, 1'b0, 6'd40, 32'h0000_4000, 1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b0);
    tv[16] = mk(4'hE, 1'b0, 6'd50, 32'h0000_5000, 1'b1, 6'd42, 32'h0000_4002, 1'b1, 6'd43, 32'h0000_4003, 4'hD, 1'b0);
    tv[17] = mk(4'h2, 1'b0, 6'd60, 32'h0000_6000, 1'b1, 6'd41, 32'h0000_4001, 1'b1, 6'd52, 32'h0000_5002, 4'hF, 1'b1);
    tv[18] = mk(4'h0, 1'b0, 6'd0,  32'h0,         1'b1, 6'd53, 32'h0000_5003, 1'b1, 6'd51, 32'h0000_5001, 4'hF, 1'b1);
    tv[19] = mk(4'h0, 1'b0, 6'd0,  32'h0,         1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b1);
    tv[20] = mk(4'h7, 1'b0, 6'd56, 32'h0000_7000, 1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b1);
    tv[21] = mk(4'h8, 1'b1, 6'd60, 32'h0000_8000, 1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b1);
    tv[22] = mk(4'h0, 1'b0, 6'd0,  32'h0,         1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b1);
    tv[23] = mk(4'h0, 1'b0, 6'd0,  32'h0,         1'b0, INV,   32'h0,        1'b0, INV,   32'h0,        4'hF, 1'b1);

    // Reset values, sampled while reset is still asserted.
    #12;
    chk("rst_c1",  64'(CDBiscast),  64'(1'b0));
    chk("rst_t1",  64'(CDBrobNum),  64'(INV));
    chk("rst_d1",  64'(CDBdata),    64'(32'h0));
    chk("rst_c2",  64'(CDBiscast2), 64'(1'b0));
    chk("rst_t2",  64'(CDBrobNum2), 64'(INV));
    chk("rst_d2",  64'(CDBdata2),   64'(32'h0));
    chk("rst_rdy", 64'(src_ready),  64'(4'hF));
    chk("rst_ovf", 64'(overflow),   64'(1'b0));
    reset = 1'b1;

    // Directed vectors.
    for (int r = 0; r < 24; r++) begin
      src_valid = tv[r].v;
      flush     = tv[r].fl;
      for (int i = 0; i < NS; i++) begin
        src_robNum[i*6 +: 6]  = tv[r].tb + 6'(i);
        src_data[i*32 +: 32]  = tv[r].db + 32'(i);
      end
      tick();
      chk($sformatf("row%0d_c1", r),  64'(CDBiscast),  64'(tv[r].c1));
      chk($sformatf("row%0d_t1", r),  64'(CDBrobNum),  64'(tv[r].t1));
      chk($sformatf("row%0d_d1", r),  64'(CDBdata),    64'(tv[r].d1));
      chk($sformatf("row%0d_c2", r),  64'(CDBiscast2), 64'(tv[r].c2));
      chk($sformatf("row%0d_t2", r),  64'(CDBrobNum2), 64'(tv[r].t2));
      chk($sformatf("row%0d_d2", r),  64'(CDBdata2),   64'(tv[r].d2));
      chk($sformatf("row%0d_rdy", r), 64'(src_ready),  64'(tv[r].rdy));
      chk($sformatf("row%0d_ovf", r), 64'(overflow),   64'(tv[r].ovf));
    end
    flush     = 1'b0;
    src_valid = 4'b0;

    // Reset asserted mid-cycle while results are on the bus and still buffered.
    src_valid = 4'h7;
    for (int i = 0; i < NS; i++) begin
      src_robNum[i*6 +: 6] = 6'd10 + 6'(i);
      src_data[i*32 +: 32] = $urandom;
    end
    tick();
    model_check("mr_push");
    src_valid = 4'h0;
    tick();
    model_check("mr_bcast");
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    model_check("mr_async");
    @(posedge clock);
    #1;
    reset = 1'b1;
    model_check("mr_held");
    src_valid = 4'h8;
    src_robNum[18 +: 6] = 6'd7;
    src_data[96 +: 32]  = 32'hCAFE_0007;
    tick();
    model_check("mr_post1");
    src_valid = 4'h0;
    tick();
    model_check("mr_post2");

    // Randomized traffic with occasional flushes.
    for (int c = 0; c < 400; c++) begin
      src_valid = 4'($urandom);
      flush     = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < NS; i++) begin
        src_robNum[i*6 +: 6] = 6'($urandom);
        src_data[i*32 +: 32] = $urandom;
      end
      tick();
      model_check($sformatf("rnd%0d", c));
    end
    src_valid = 4'h0;
    flush     = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      model_check($sformatf("drain%0d", c));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
